bypass_subtractor_seq: RTL and testbench

- Block-serial carry-skip subtractor: the subtraction counterpart of the team's bypass adder.
- Computes Diff = A - B - Bin, one K-bit block per clock.
- Per-block borrow-skip: when every bit pair in a block is equal, the block's borrow-in passes straight to its borrow-out.
- Sits on the datapath behind a valid/ready handshake and trades area for latency against the combinational adder.

---
 rtl/bypass_subtractor_seq.sv | 190 +++++++++++++++++++
 tb/tb_bypass_subtractor_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bypass_subtractor_seq.sv
// Block-serial borrow-skip subtractor: Diff = A - B - Bin, one K-bit block
// per clock, behind a valid/ready handshake. A block whose bit pairs are all
// equal forwards its borrow-in straight to its borrow-out and is counted in
// skip_count.
module bypass_subtractor_seq #(
  parameter int N = 32,
  parameter int K = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N-1:0]                        A,
  input  logic [N-1:0]                        B,
  input  logic                                Bin,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [N-1:0]                        Diff,
  output logic                                Bout,
  output logic [$clog2((N+K-1)/K+1)-1:0]      skip_count
);

  localparam int NUM_BLOCKS = (N + K - 1) / K;
  localparam int PW         = NUM_BLOCKS * K;
  localparam int SC_W       = $clog2(NUM_BLOCKS + 1);
  localparam int IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     a_q, a_d;
  logic [PW-1:0]     b_q, b_d;
  logic              borrow_q, borrow_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N-1:0]      diff_q, diff_d;
  logic              bout_q, bout_d;
  logic [SC_W-1:0]   skip_q, skip_d;

  logic [K-1:0]      blk_a_s;
  logic [K-1:0]      blk_b_s;
  logic [K+1:0]      blk_res_s;
  logic [K-1:0]      blk_diff_s;
  logic              blk_skip_s;
  logic              blk_bout_s;
  logic [PW-1:0]     ins_s;
  logic [PW-1:0]     msk_s;
  logic [PW-1:0]     diff_pad_s;

  // One block of ripple subtraction with the borrow-skip decision.
  // Returns {block borrow-out, skip taken, difference bits}.
  function automatic logic [K+1:0] block_sub(input logic [K-1:0] a,
                                             input logic [K-1:0] b,
                                             input logic         bi);
    logic [K:0]   br;
    logic [K-1:0] d;
    logic         eq_all;
    br[0] = bi;
    for (int j = 0; j < K; j++) begin
      d[j]    = a[j] ^ b[j] ^ br[j];
      br[j+1] = (~a[j] & b[j]) | (~(a[j] ^ b[j]) & br[j]);
    end
    eq_all = &(~(a ^ b));
    return {(eq_all ? bi : br[K]), eq_all, d};
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, walk the blocks in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = RUN;
        else          state_d = IDLE;
      end
      RUN: begin
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   state_d = RUN;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = ~rst;
      RUN:     in_ready  = 1'b0;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Current block slice and its subtraction result; operands are zero-padded
  // so the top block reads equal pairs beyond bit N-1.
  always_comb begin
    blk_a_s    = K'(a_q >> (K * int'(idx_q)));
    blk_b_s    = K'(b_q >> (K * int'(idx_q)));
    blk_res_s  = block_sub(blk_a_s, blk_b_s, borrow_q);
    blk_diff_s = blk_res_s[K-1:0];
    blk_skip_s = blk_res_s[K];
    blk_bout_s = blk_res_s[K+1];
    msk_s      = PW'({K{1'b1}}) << (K * int'(idx_q));
    ins_s      = PW'(blk_diff_s) << (K * int'(idx_q));
    diff_pad_s = (PW'(diff_q) & ~msk_s) | ins_s;
  end

  // Datapath next-state: capture on acceptance, one block per RUN cycle.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    skip_d   = skip_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = PW'(A);
          b_d      = PW'(B);
          borrow_d = Bin;
          idx_d    = '0;
          diff_d   = '0;
          bout_d   = 1'b0;
          skip_d   = '0;
        end else begin
          a_d = a_q;
        end
      end
      RUN: begin
        diff_d   = N'(diff_pad_s);
        borrow_d = blk_bout_s;
        if (blk_skip_s) skip_d = skip_q + SC_W'(1);
        else            skip_d = skip_q;
        if (idx_q == LAST_IDX) bout_d = blk_bout_s;
        else                   idx_d  = idx_q + IDX_W'(1);
      end
      DONE:    diff_d = diff_q;
      default: diff_d = diff_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      skip_q   <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      skip_q   <= skip_d;
    end
  end

  assign Diff       = diff_q;
  assign Bout       = bout_q;
  assign skip_count = skip_q;

endmodule

// File: tb/tb_bypass_subtractor_seq.sv
// Randomized bench for bypass_subtractor_seq: a 32/4 instance and a 10/4
// instance checked against an arithmetic reference model.
module tb_bypass_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bin_s = 1'b0;
  logic        out_ready = 1'b1;

  logic        iv32 = 1'b0, ir32, ov32, bo32;
  logic [31:0] a32 = 32'd0, b32 = 32'd0, d32;
  logic [3:0]  sc32;

  logic        iv10 = 1'b0, ir10, ov10, bo10;
  logic [9:0]  a10 = 10'd0, b10 = 10'd0, d10;
  logic [1:0]  sc10;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bypass_subtractor_seq #(.N(32), .K(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
    .A(a32), .B(b32), .Bin(bin_s), .out_valid(ov32), .out_ready(out_ready),
    .Diff(d32), .Bout(bo32), .skip_count(sc32)
  );

  bypass_subtractor_seq #(.N(10), .K(4)) dut10 (
    .clk(clk), .rst(rst), .in_valid(iv10), .in_ready(ir10),
    .A(a10), .B(b10), .Bin(bin_s), .out_valid(ov10), .out_ready(out_ready),
    .Diff(d10), .Bout(bo10), .skip_count(sc10)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: modular difference, unsigned compare for the borrow, and a
  // count of blocks whose operand bits are identical (padding counts as equal).
  function automatic void ref_sub(input logic [31:0] a, input logic [31:0] b,
                                  input logic bin, input int n, input int k,
                                  output logic [31:0] d, output logic bo, output int sk);
    logic [63:0] m, am, bm, km;
    int nb;
    m  = (64'd1 << n) - 64'd1;
    km = (64'd1 << k) - 64'd1;
    am = 64'(a) & m;
    bm = 64'(b) & m;
    d  = 32'((am - bm - 64'(bin)) & m);
    bo = (am < bm + 64'(bin));
    nb = (n + k - 1) / k;
    sk = 0;
    for (int i = 0; i < nb; i++)
      if ((((am ^ bm) >> (i * k)) & km) == 64'd0) sk++;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [31:0] ed32, ed10, gd32, gd10;
    logic        eb32, eb10, gb32, gb10;
    int          es32, es10, gs32, gs10, lat32, lat10;
    ref_sub(a, b, bin, 32, 4, ed32, eb32, es32);
    ref_sub(a, b, bin, 10, 4, ed10, eb10, es10);
    @(negedge clk);
    check("in_ready32", 64'(ir32), 64'd1);
    check("in_ready10", 64'(ir10), 64'd1);
    a32 = a; b32 = b; a10 = a[9:0]; b10 = b[9:0]; bin_s = bin;
    iv32 = 1'b1; iv10 = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    iv32 = 1'b0; iv10 = 1'b0;
    lat32 = -1; lat10 = -1;
    gd32 = 32'd0; gd10 = 32'd0; gb32 = 1'b0; gb10 = 1'b0; gs32 = 0; gs10 = 0;
    for (int c = 1; c <= 20 && (lat32 < 0 || lat10 < 0); c++) begin
      @(negedge clk);
      if (ov32 && lat32 < 0) begin lat32 = c; gd32 = d32; gb32 = bo32; gs32 = int'(sc32); end
      if (ov10 && lat10 < 0) begin lat10 = c; gd10 = 32'(d10); gb10 = bo10; gs10 = int'(sc10); end
    end
    check("lat32",  64'(lat32), 64'd8);
    check("diff32", 64'(gd32), 64'(ed32));
    check("bout32", 64'(gb32), 64'(eb32));
    check("skip32", 64'(gs32), 64'(es32));
    check("lat10",  64'(lat10), 64'd3);
    check("diff10", 64'(gd10), 64'(ed10));
    check("bout10", 64'(gb10), 64'(eb10));
    check("skip10", 64'(gs10), 64'(es10));
  endtask

  initial begin : main
    logic [31:0] ra, rb, hold_d;
    logic        hold_b;
    logic [3:0]  hold_s;
    int          seen, wait_c;

    // Reset state.
    #12;
    check("rst_in_ready", 64'(ir32), 64'd0);
    check("rst_out_valid", 64'(ov32), 64'd0);
    check("rst_diff", 64'(d32), 64'd0);
    check("rst_bout", 64'(bo32), 64'd0);
    check("rst_skip", 64'(sc32), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0);
    check("dir_5m3", 64'(d32), 64'h0000_0002);
    check("dir_5m3_skip", 64'(sc32), 64'd7);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0);
    check("dir_0m1", 64'(d32), 64'hFFFF_FFFF);
    check("dir_0m1_bout", 64'(bo32), 64'd1);
    check("dir10_0m1", 64'(d10), 64'h3FF);
    check("dir10_0m1_skip", 64'(sc10), 64'd2);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1);
    check("dir_eq_skip", 64'(sc32), 64'd8);
    check("dir_eq_diff", 64'(d32), 64'hFFFF_FFFF);

    // Backpressure: hold DONE, pulse in_valid with new operands.
    @(negedge clk);
    a32 = 32'h0000_00FF; b32 = 32'h0000_000F; bin_s = 1'b0;
    iv32 = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    iv32 = 1'b0;
    wait_c = 0;
    while (!ov32 && wait_c < 20) begin @(negedge clk); wait_c++; end
    check("bp_valid", 64'(ov32), 64'd1);
    check("bp_diff", 64'(d32), 64'h0000_00F0);
    hold_d = d32; hold_b = bo32; hold_s = sc32;
    for (int i = 0; i < 5; i++) begin
      a32 = $urandom; b32 = $urandom; iv32 = 1'(i % 2 == 0);
      @(negedge clk);
      check("bp_hold_valid", 64'(ov32), 64'd1);
      check("bp_hold_ready", 64'(ir32), 64'd0);
      check("bp_hold_diff", 64'(d32), 64'(hold_d));
      check("bp_hold_bout", 64'(bo32), 64'(hold_b));
      check("bp_hold_skip", 64'(sc32), 64'(hold_s));
    end
    iv32 = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(ov32), 64'd0);
    check("bp_release_ready", 64'(ir32), 64'd1);
    check("bp_release_hold", 64'(d32), 64'(hold_d));

    // Abort at RUN with idx==3.
    a32 = 32'h0000_0000; b32 = 32'h0000_0001; bin_s = 1'b0; iv32 = 1'b1;
    @(negedge clk);
    iv32 = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_partial", 64'(d32), 64'h0000_0FFF);
    rst = 1'b1;
    #1;
    check("abort_valid", 64'(ov32), 64'd0);
    check("abort_diff", 64'(d32), 64'd0);
    check("abort_bout", 64'(bo32), 64'd0);
    check("abort_skip", 64'(sc32), 64'd0);
    check("abort_ready", 64'(ir32), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov32) seen++;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    run_op(32'h0000_0010, 32'h0000_0001, 1'b0);
    check("post_abort_diff", 64'(d32), 64'h0000_000F);
    check("post_abort_skip", 64'(sc32), 64'd6);

    // Randomized operations, biased toward equal or nearly equal operands.
    for (int t = 0; t < 40; t++) begin
      ra = $urandom;
      case ($urandom_range(3, 0))
        0:       rb = ra;
        1:       rb = ra ^ (32'd1 << $urandom_range(31, 0));
        2:       rb = ra ^ (32'hF << (4 * $urandom_range(7, 0)));
        default: rb = $urandom;
      endcase
      run_op(ra, rb, 1'($urandom_range(1, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
